sram_burst_arbiter: RTL
=======================

Name: sram_burst_arbiter

Overview:
- Shares one single-port SRAM macro (active-low CEB/WEB, 1-cycle registered read) among NUM_REQ requesters in the MAC engine, e.g. weight loader, activation streamer and output writer.
- Grants whole bursts round-robin and auto-increments addresses.
- Routes read data back with a per-requester valid strobe.
- Sits between the engine's streamers and the SRAM instance.

Parameters:
- NUM_REQ, 2, number of requesters (>=2).
- numWord, 2048, SRAM depth in words; AW = $clog2(numWord).
- numBit, 32, SRAM word width.
- MAX_BURST, 16, maximum beats per burst; LW = $clog2(MAX_BURST).

Ports:
- CLK  in  1  clock.
- reset  in  1  active-low asynchronous reset.
- req_i  in  NUM_REQ  burst request, held until gnt.
- req_we_i  in  NUM_REQ  1 = write burst, 0 = read burst.
- req_addr_i  in  NUM_REQ*AW  start address, slice r = requester r.
- req_len_i  in  NUM_REQ*LW  beats minus one.
- gnt_o  out  NUM_REQ  one-cycle accept pulse.
- wdata_i  in  NUM_REQ*numBit  write data of current beat.
- wready_o  out  NUM_REQ  write beat consumed this cycle.
- rvalid_o  out  NUM_REQ  rdata_o valid for requester.
- rdata_o  out  numBit  read data, wired from sram_q_i.
- busy_o  out  1  burst in progress.
- sram_ceb_o, sram_web_o  out  1 each  SRAM chip enable / write enable, both active-low.
- sram_a_o  out  AW  SRAM address.
- sram_d_o  out  numBit  SRAM write data.
- sram_q_i  in  numBit  SRAM read data.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Clock port is CLK; reset port is reset.
- Reset values:
  - state = IDLE; rr pointer = NUM_REQ-1, so requester 0 wins first.
  - gnt_o, wready_o, rvalid_o = 0; busy_o = 0.
  - sram_ceb_o = 1, sram_web_o = 1, sram_a_o = 0, sram_d_o = 0.
  - Counters and latched attributes = 0.
- FSM states: IDLE and BURST.
- IDLE:
  - SRAM idle: CEB = 1, WEB = 1, A = 0, D = 0.
  - If any req_i is high, select the first set bit searching from ptr+1 upward, with wrap.
  - Pulse gnt_o[winner] for that cycle.
  - Latch owner, we, addr and remaining = req_len for the winner; set ptr = winner; go to BURST.
- BURST: exactly one beat per cycle.
  - CEB = 0, WEB = ~we, A = cur_addr.
  - D = wdata slice of owner for writes, 0 for reads.
  - Writes: wready_o[owner] = 1 each beat. The requester must present the next word every cycle; there is no backpressure.
  - Reads: rvalid_o[owner] = 1 on the cycle after the beat, with rdata_o = sram_q_i.
  - cur_addr increments each beat and wraps numWord-1 -> 0.
  - When remaining == 0 on a beat, return to IDLE next cycle; otherwise decrement remaining.
  - busy_o = 1 throughout BURST.
- Latency:
  - req seen in IDLE at cycle t: gnt at t, first beat at t+1.
  - First read data at t+2; last read data at t+2+len.
- Bursts are never preempted.
- req_i changes during BURST are ignored.
- Attributes are sampled only on the gnt cycle.
- There is a mandatory one-cycle IDLE bubble between bursts. The rvalid of a burst's last read beat overlaps that bubble.
- A requester must drop req_i the cycle after gnt or it is re-arbitrated in the next IDLE as a new burst.
- Simultaneous requests resolve round-robin only; there is no fixed priority.
- Reset mid-burst:
  - Abort immediately; all outputs return to reset values.
  - No rvalid is issued for the outstanding read.
- len = 0 gives a single-beat burst.

Decomposition:
- Package sram_arb_pkg holds:
  - state enum (IDLE, BURST);
  - AW/LW derivation helpers;
  - beat-attribute struct (we, addr, remaining).
- One combinational sub-module rr_pick: inputs req vector and ptr, outputs one-hot winner and valid.
- The FSM, counters and rvalid register live in the top.

Test Plan:
- Single read, len = 3, addr = 10, requester 0:
  - gnt at t, A = 10..13 at t+1..t+4;
  - rvalid_o[0] at t+2..t+5 with the preloaded words.
- Write burst, len = 1, addr = 2046, requester 1:
  - A = 2046 then 2047, wready_o[1] on both beats.
  - Readback of both words matches.
- Wrap: write burst len = 3 at 2046, numWord = 2048:
  - A sequence 2046, 2047, 0, 1.
  - Read back at 0 returns the third word.
- Both requesters held high continuously, len = 0:
  - gnt alternates 0, 1, 0, 1;
  - one IDLE bubble between each pair of beats.
- Requester 1 drops req_i mid-burst (len = 7):
  - all 8 beats still issued; busy_o stays high 8 cycles.
- reset asserted on 3rd beat of read burst:
  - CEB = 1, rvalid_o = 0 immediately;
  - after release requester 0 wins first.

Source files
------------

// File: rtl/sram_burst_arbiter_pkg.sv
// Shared types and width helpers for the SRAM burst arbiter.
package sram_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Upper bounds for the beat-attribute fields; real widths are sliced in the top.
  localparam int unsigned MAX_AW = 32;
  localparam int unsigned MAX_LW = 16;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned len_width(input int unsigned max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

  typedef struct packed {
    logic              we;
    logic [MAX_AW-1:0] addr;
    logic [MAX_LW-1:0] remaining;
  } beat_t;

endpackage

// File: rtl/sram_burst_arbiter_if.sv
// Requester-side burst bus of the SRAM arbiter, slices indexed by requester.
interface sram_burst_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned AW      = 11,
  parameter int unsigned LW      = 4,
  parameter int unsigned numBit  = 32
);
  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ-1:0]        req_we_i;
  logic [NUM_REQ*AW-1:0]     req_addr_i;
  logic [NUM_REQ*LW-1:0]     req_len_i;
  logic [NUM_REQ-1:0]        gnt_o;
  logic [NUM_REQ*numBit-1:0] wdata_i;
  logic [NUM_REQ-1:0]        wready_o;
  logic [NUM_REQ-1:0]        rvalid_o;
  logic [numBit-1:0]         rdata_o;
  logic                      busy_o;

  modport master (
    output req_i, req_we_i, req_addr_i, req_len_i, wdata_i,
    input  gnt_o, wready_o, rvalid_o, rdata_o, busy_o
  );

  modport slave (
    input  req_i, req_we_i, req_addr_i, req_len_i, wdata_i,
    output gnt_o, wready_o, rvalid_o, rdata_o, busy_o
  );
endinterface

// File: rtl/sram_burst_arbiter_rr_pick.sv
// Round-robin picker: first set request searching upward from ptr+1 with wrap.
module rr_pick #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);
  logic [PW-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = PW'((32'(ptr) + i) % NUM_REQ);
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sram_burst_arbiter.sv
// Shares one single-port SRAM among NUM_REQ requesters, granting whole
// auto-incrementing bursts round-robin and steering read data back.
module sram_burst_arbiter
  import sram_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ   = 2,
  parameter  int unsigned numWord   = 2048,
  parameter  int unsigned numBit    = 32,
  parameter  int unsigned MAX_BURST = 16,
  localparam int unsigned AW        = addr_width(numWord),
  localparam int unsigned LW        = len_width(MAX_BURST)
) (
  input  logic                 CLK,
  input  logic                 reset,
  sram_burst_arbiter_if.slave  bus,
  output logic                 sram_ceb_o,
  output logic                 sram_web_o,
  output logic [AW-1:0]        sram_a_o,
  output logic [numBit-1:0]    sram_d_o,
  input  logic [numBit-1:0]    sram_q_i
);
  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state_q;
  beat_t              beat_q;
  logic [PW-1:0]      owner_q;
  logic [PW-1:0]      ptr_q;
  logic [NUM_REQ-1:0] rvalid_q;
  logic [NUM_REQ-1:0] win_oh;
  logic               win_valid;
  logic [PW-1:0]      win_idx;
  logic [NUM_REQ-1:0] owner_oh;
  logic [AW-1:0]      cur_addr;
  logic [AW-1:0]      next_addr;
  logic [LW-1:0]      remaining;
  logic               unused_hi;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (bus.req_i),
    .ptr    (ptr_q),
    .winner (win_oh),
    .valid  (win_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      if (win_oh[i]) win_idx = PW'(i);
  end

  assign owner_oh  = NUM_REQ'(1) << owner_q;
  assign cur_addr  = beat_q.addr[AW-1:0];
  assign remaining = beat_q.remaining[LW-1:0];
  assign next_addr = (cur_addr == AW'(numWord - 1)) ? '0 : cur_addr + AW'(1);
  assign unused_hi = ^{beat_q.addr[MAX_AW-1:AW], beat_q.remaining[MAX_LW-1:LW]};

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      owner_q  <= '0;
      ptr_q    <= PW'(NUM_REQ - 1);
      rvalid_q <= '0;
    end else begin
      rvalid_q <= '0;
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            state_q          <= BURST;
            owner_q          <= win_idx;
            ptr_q            <= win_idx;
            beat_q.we        <= bus.req_we_i[win_idx];
            beat_q.addr      <= MAX_AW'(bus.req_addr_i[win_idx*AW +: AW]);
            beat_q.remaining <= MAX_LW'(bus.req_len_i[win_idx*LW +: LW]);
          end
        end
        BURST: begin
          // Read data returns one cycle after its beat, matching the SRAM's registered output.
          if (!beat_q.we) rvalid_q <= owner_oh;
          beat_q.addr <= MAX_AW'(next_addr);
          if (remaining == '0) state_q <= IDLE;
          else                 beat_q.remaining <= MAX_LW'(remaining - LW'(1));
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    sram_ceb_o   = 1'b1;
    sram_web_o   = 1'b1;
    sram_a_o     = '0;
    sram_d_o     = '0;
    bus.wready_o = '0;
    if (state_q == BURST) begin
      sram_ceb_o = 1'b0;
      sram_web_o = ~beat_q.we;
      sram_a_o   = cur_addr;
      if (beat_q.we) begin
        sram_d_o     = bus.wdata_i[owner_q*numBit +: numBit];
        bus.wready_o = owner_oh;
      end
    end
  end

  // Grant is gated by reset so it stays low while reset is held.
  assign bus.gnt_o    = (state_q == IDLE && reset) ? win_oh : '0;
  assign bus.busy_o   = (state_q == BURST);
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = sram_q_i;

endmodule
